// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: op encoding, FSM states,
// and the counter width for the default operand width.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    MULTU = 2'b00,
    MULT  = 2'b01,
    DIVU  = 2'b10,
    DIV   = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Controller-side bus of the multiply/divide unit: start/busy/done handshake,
// mthi/mtlo writes and the architectural HI/LO outputs.
interface muldiv_unit_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, wr_data,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, wr_data,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/muldiv_unit_cond_neg.sv
// Conditional two's-complement negate; cin_i lets the upper half of a
// double-width negate take the borrow out of the lower half.
module cond_neg #(
  parameter int WIDTH = 32
) (
  input  logic             en_i,
  input  logic             cin_i,
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = en_i ? (~x_i + {{(WIDTH-1){1'b0}}, cin_i}) : x_i;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide with HI/LO registers, fixed WIDTH+1 edge latency.
// Signed MULT/DIV only when MULDIV_SIGNED_EN is defined; otherwise all ops are unsigned.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  muldiv_state_t      state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic               div_q, div_d, neg_q, neg_d, sa_q, sa_d;
  logic               done_q, done_d, dz_q, dz_d;

  logic               sgn;
  logic [WIDTH-1:0]   a_mag, b_mag, lo_fix, hi_fix;
  logic [WIDTH:0]     mul_sum, div_tmp;
  logic               div_ge;

`ifdef MULDIV_SIGNED_EN
  assign sgn = bus.op[0];

  cond_neg #(.WIDTH(WIDTH)) u_abs_a (
    .en_i(sgn & bus.a[WIDTH-1]), .cin_i(1'b1), .x_i(bus.a), .y_o(a_mag));
  cond_neg #(.WIDTH(WIDTH)) u_abs_b (
    .en_i(sgn & bus.b[WIDTH-1]), .cin_i(1'b1), .x_i(bus.b), .y_o(b_mag));
  cond_neg #(.WIDTH(WIDTH)) u_fix_lo (
    .en_i(neg_q), .cin_i(1'b1), .x_i(acc_q[WIDTH-1:0]), .y_o(lo_fix));
  // Product high half borrows from the low half only when the low half is zero.
  cond_neg #(.WIDTH(WIDTH)) u_fix_hi (
    .en_i (div_q ? sa_q : neg_q),
    .cin_i(div_q | (acc_q[WIDTH-1:0] == '0)),
    .x_i  (acc_q[2*WIDTH-1:WIDTH]),
    .y_o  (hi_fix));
`else
  assign sgn    = 1'b0;
  assign a_mag  = bus.a;
  assign b_mag  = bus.b;
  assign lo_fix = acc_q[WIDTH-1:0];
  assign hi_fix = acc_q[2*WIDTH-1:WIDTH];
  logic unused_sign;
  assign unused_sign = ^{bus.op[0], sa_q, neg_q};
`endif

  // acc = {partial product, multiplier} for multiply, {remainder, quotient} for divide.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
  assign div_tmp = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge  = (div_tmp >= {1'b0, b_q});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    neg_d   = neg_q;
    sa_d    = sa_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.wr_hi) hi_d = bus.wr_data;
        if (bus.wr_lo) lo_d = bus.wr_data;
        if (bus.start) begin
          state_d = CALC;
          cnt_d   = CW'(WIDTH - 1);
          acc_d   = {{WIDTH{1'b0}}, a_mag};
          b_d     = b_mag;
          div_d   = bus.op[1];
          neg_d   = sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          sa_d    = sgn & bus.a[WIDTH-1];
        end
      end
      CALC: begin
        if (div_q) begin
          acc_d = div_ge ? {div_tmp[WIDTH-1:0] - b_q, acc_q[WIDTH-2:0], 1'b1}
                         : {div_tmp[WIDTH-1:0],       acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        hi_d    = hi_fix;
        lo_d    = lo_fix;
        done_d  = 1'b1;
        dz_d    = div_q & (b_q == '0);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      sa_q    <= sa_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.dz   = dz_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32; expectations follow MULDIV_SIGNED_EN.
module tb_muldiv_unit;
  import muldiv_pkg::*;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int edges, busyc, done_cyc;
  logic dz_s;

  always @(posedge clk) cyc <= cyc + 1;

  // Start an op, then wait (bounded) for done; leaves time at posedge+1 of the done cycle.
  task automatic run_op(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    edges = 0;
    busyc = bus.busy ? 1 : 0;
    while (!bus.done && edges < 60) begin
      @(posedge clk); #1;
      edges++;
      if (bus.busy) busyc++;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++; $display("FAIL done_timeout: op=%0d got no done within %0d edges", op, edges);
    end
    done_cyc = cyc;
    dz_s = bus.dz;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus.start = 0; bus.op = MULTU; bus.a = '0; bus.b = '0;
    bus.wr_hi = 0; bus.wr_lo = 0; bus.wr_data = '0;
    #12;
    checks++;
    if ({bus.busy, bus.done, bus.dz} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.dz});
    end
    checks++;
    if (bus.hi !== '0 || bus.lo !== '0) begin
      errors++; $display("FAIL reset_hilo: got %h/%h expected 0/0", bus.hi, bus.lo);
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_multu;
    run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checks++;
    if (bus.hi !== 32'hFFFFFFFE || bus.lo !== 32'h00000001) begin
      errors++; $display("FAIL multu_full: got %h/%h expected fffffffe/00000001", bus.hi, bus.lo);
    end
    checks++;
    if (edges !== 33) begin
      errors++; $display("FAIL multu_latency: got %0d edges expected 33", edges);
    end
    checks++;
    if (busyc !== 33) begin
      errors++; $display("FAIL multu_busy_cycles: got %0d expected 33", busyc);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL busy_at_done: got %b expected 0", bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL done_pulse: got %b expected 0", bus.done);
    end
  endtask

  task automatic test_mult;
    logic [W-1:0] exp_hi;
`ifdef MULDIV_SIGNED_EN
    exp_hi = 32'hFFFFFFFF;
`else
    exp_hi = 32'h00000006;
`endif
    run_op(MULT, 32'hFFFFFFFD, 32'd7);
    checks++;
    if (bus.hi !== exp_hi || bus.lo !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL mult_mixed: got %h/%h expected %h/ffffffeb", bus.hi, bus.lo, exp_hi);
    end
  endtask

  task automatic test_div;
    logic [W-1:0] eh, el;
`ifdef MULDIV_SIGNED_EN
    eh = 32'hFFFFFFFF; el = 32'hFFFFFFFD;
`else
    eh = 32'h00000001; el = 32'h7FFFFFFC;
`endif
    run_op(DIV, 32'hFFFFFFF9, 32'd2);
    checks++;
    if (bus.hi !== eh || bus.lo !== el) begin
      errors++; $display("FAIL div_neg_dividend: got %h/%h expected %h/%h", bus.hi, bus.lo, eh, el);
    end
    run_op(DIVU, 32'd7, 32'd2);
    checks++;
    if (bus.hi !== 32'd1 || bus.lo !== 32'd3 || dz_s !== 1'b0) begin
      errors++; $display("FAIL divu_7_2: got %h/%h dz=%b expected 1/3 dz=0", bus.hi, bus.lo, dz_s);
    end
`ifdef MULDIV_SIGNED_EN
    eh = 32'd1; el = 32'hFFFFFFFD;
`else
    eh = 32'd7; el = 32'd0;
`endif
    run_op(DIV, 32'd7, 32'hFFFFFFFE);
    checks++;
    if (bus.hi !== eh || bus.lo !== el) begin
      errors++; $display("FAIL div_neg_divisor: got %h/%h expected %h/%h", bus.hi, bus.lo, eh, el);
    end
  endtask

  task automatic test_div_corner;
    logic [W-1:0] eh, el;
    run_op(DIVU, 32'd5, 32'd0);
    checks++;
    if (bus.hi !== 32'd5 || bus.lo !== 32'hFFFFFFFF || dz_s !== 1'b1) begin
      errors++; $display("FAIL div_by_zero: got %h/%h dz=%b expected 5/ffffffff dz=1", bus.hi, bus.lo, dz_s);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.dz !== 1'b0) begin
      errors++; $display("FAIL dz_clear: got %b expected 0", bus.dz);
    end
`ifdef MULDIV_SIGNED_EN
    eh = 32'd0; el = 32'h80000000;
`else
    eh = 32'h80000000; el = 32'd0;
`endif
    run_op(DIV, 32'h80000000, 32'hFFFFFFFF);
    checks++;
    if (bus.hi !== eh || bus.lo !== el || dz_s !== 1'b0) begin
      errors++; $display("FAIL div_min_neg1: got %h/%h dz=%b expected %h/%h dz=0", bus.hi, bus.lo, dz_s, eh, el);
    end
  endtask

  task automatic test_back_to_back;
    int c1;
    run_op(MULTU, 32'd3, 32'd5);
    c1 = done_cyc;
    checks++;
    if (bus.lo !== 32'd15 || bus.hi !== 32'd0) begin
      errors++; $display("FAIL b2b_first: got %h/%h expected 0/f", bus.hi, bus.lo);
    end
    run_op(DIVU, 32'd100, 32'd7);
    checks++;
    if (done_cyc - c1 !== 34) begin
      errors++; $display("FAIL b2b_spacing: got %0d cycles expected 34", done_cyc - c1);
    end
    checks++;
    if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      errors++; $display("FAIL b2b_second: got %h/%h expected 2/e", bus.hi, bus.lo);
    end
  endtask

  task automatic test_handshake;
    int dones;
    logic [W-1:0] prev_hi, res_hi, res_lo;
    prev_hi = bus.hi;
    dones = 0; res_hi = '0; res_lo = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = MULTU; bus.a = 32'd6; bus.b = 32'd7;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd100;
    bus.wr_hi = 1'b1; bus.wr_data = 32'hDEAD;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.wr_hi = 1'b0;
    checks++;
    if (bus.hi !== prev_hi) begin
      errors++; $display("FAIL wr_hi_busy: got %h expected %h", bus.hi, prev_hi);
    end
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin dones++; res_hi = bus.hi; res_lo = bus.lo; end
    end
    checks++;
    if (dones !== 1) begin
      errors++; $display("FAIL start_while_busy: got %0d dones expected 1", dones);
    end
    checks++;
    if (res_hi !== 32'd0 || res_lo !== 32'd42) begin
      errors++; $display("FAIL busy_op_result: got %h/%h expected 0/2a", res_hi, res_lo);
    end
    @(negedge clk);
    bus.wr_lo = 1'b1; bus.wr_data = 32'h1234;
    @(posedge clk); #1; bus.wr_lo = 1'b0;
    checks++;
    if (bus.lo !== 32'h1234 || bus.hi !== 32'd0) begin
      errors++; $display("FAIL mtlo_idle: got %h/%h expected 0/1234", bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_midop;
    @(negedge clk);
    bus.wr_hi = 1'b1; bus.wr_data = 32'h55;
    @(posedge clk); #1; bus.wr_hi = 1'b0;
    checks++;
    if (bus.hi !== 32'h55) begin
      errors++; $display("FAIL mthi_idle: got %h expected 55", bus.hi);
    end
    @(negedge clk);
    bus.start = 1'b1; bus.op = MULTU; bus.a = 32'd9; bus.b = 32'd9;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.dz} !== 3'b000 || bus.hi !== '0 || bus.lo !== '0) begin
      errors++; $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h expected all 0",
                         bus.busy, bus.done, bus.hi, bus.lo);
    end
    @(negedge clk); reset_n = 1'b1;
    run_op(MULTU, 32'd3, 32'd4);
    checks++;
    if (bus.lo !== 32'd12 || bus.hi !== 32'd0 || edges !== 33) begin
      errors++; $display("FAIL after_reset_op: got %h/%h edges=%0d expected 0/c edges=33", bus.hi, bus.lo, edges);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_corner();
    test_back_to_back();
    test_handshake();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
